aes_key_expander: RTL and testbench
===================================

Name: aes_key_expander

Overview:
- Writer/responder side of the round-key lookup interface (`round_key_addr` in, `round_key` out) used by the AES scheduler.
- Accepts a 128-bit AES-128 cipher key as four 32-bit words on a valid/ready sink stream.
- Expands the key into 11 round keys (FIPS-197) and stores them in an internal 11x128 register file.
- Serves round keys by address to the scheduler and its cores.

Parameters:
- REG_OUT, 1, 1 = `round_key` registered (1-cycle read latency); 0 = combinational read from the register file.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- key_valid  input  1  sink word valid.
- key_data  input  32  key word; first accepted word = key[127:96], last = key[31:0].
- key_ready  output  1  sink ready.
- round_key_addr  input  4  round key index 0..10; 11..15 invalid.
- round_key  output  128  round key for `round_key_addr`.
- keys_valid  output  1  all 11 round keys consistent with the last loaded key.
- busy  output  1  high in LOAD or EXPAND.

Behaviour:
- Reset values:
  - state = IDLE, key_ready = 1, keys_valid = 0, busy = 0.
  - round_key = 0 (REG_OUT = 1).
  - Word and round counters = 0; register file not cleared.
- Transfer rule: a word transfers on a cycle where key_valid & key_ready.
- States:
  - IDLE: key_ready = 1. A transfer stores word 0 and moves to LOAD.
  - LOAD: key_ready = 1, busy = 1. Words 1..3 are stored.
    - On the 4th transfer, entry 0 is written with {w0, w1, w2, w3} at that clock edge.
    - State moves to EXPAND with rnd = 1.
  - EXPAND: key_ready = 0, busy = 1. One round key per cycle.
    - temp = SubWord(RotWord(prev[31:0])) ^ {Rcon[rnd], 24'h0}.
    - n0 = prev[127:96] ^ temp; n1 = prev[95:64] ^ n0; n2 = prev[63:32] ^ n1; n3 = prev[31:0] ^ n2.
    - Entry rnd is written with {n0, n1, n2, n3}.
    - Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
    - After writing rnd = 10, state moves to DONE.
  - DONE: keys_valid = 1, key_ready = 1, busy = 0.
    - A transfer starts a new key: keys_valid drops the next cycle, the word is stored as word 0, and state moves to LOAD.
- Latency: keys_valid rises exactly 11 cycles after the clock edge that accepts word 3 (1 LOAD-completion edge plus 10 EXPAND cycles).
- SubWord uses four combinational S-box instances; exactly one round key is computed per cycle.
- Read path:
  - REG_OUT = 1: round_key = entry[addr] one cycle after addr is presented.
  - REG_OUT = 0: round_key = entry[addr] in the same cycle.
  - addr 11..15 returns 128'h0.
  - Reads are always serviced, even while busy; keys_valid qualifies them.
- Gaps in key_valid during LOAD stall the load indefinitely; no timeout.
- Reset asserted mid-LOAD or mid-EXPAND: return to IDLE next edge, keys_valid = 0, partial key discarded.
- A read of entry k in the same cycle as its EXPAND write returns the old value (REG_OUT = 1).

Optional Feature:
- Macro: AES_KEY_ZEROIZE_EN.
- Defined:
  - Adds input port `zeroize` (1 bit), sampled in any state except ZERO.
  - A zeroize pulse enters state ZERO, which clears entries 0..10, one per cycle, over 11 cycles.
  - During ZERO: key_ready = 0, busy = 1, keys_valid = 0.
  - Then IDLE.
  - zeroize has priority over a simultaneous sink transfer; reset has priority over zeroize.
- Not defined: no port, no ZERO state; stored keys persist until overwritten.

Test Plan:
- Load key 2b7e1516 28aed2a6 abf71588 09cf4f3c back-to-back, wait for keys_valid, read addr 0, 1, 10 -> 2b7e151628aed2a6abf7158809cf4f3c, a0fafe1788542cb123a339392a6c7605, d014f9a8c9ee2589e13f0cc8b6630ca6; keys_valid exactly 11 cycles after word 3 accepted.
- Same key with key_valid deasserted for 3 cycles between each word -> identical round keys; busy high from word 0 to expansion end.
- Assert reset 5 cycles into EXPAND -> IDLE, keys_valid = 0, busy = 0, key_ready = 1 next cycle; a subsequent full load yields the correct keys.
- In DONE, load all-zero key -> keys_valid drops the cycle after word 0; addr 1 afterwards = 62636363626363636263636362636363; addr 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Read addr 11 and 15 -> 128'h0; with REG_OUT = 1 the addr-to-data latency is exactly 1 cycle.
- AES_KEY_ZEROIZE_EN: after a valid load, pulse zeroize -> keys_valid = 0, key_ready = 0 for 11 cycles, then all of addr 0..10 read 0.

Source files
------------

// File: rtl/aes_key_expander.sv
// AES-128 key expander: loads a cipher key word-by-word, expands it into 11 round keys
// and serves them by address. Define AES_KEY_ZEROIZE_EN to add a zeroize input and wipe state.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] xa;
        p  = 8'h00;
        xa = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ xa;
            xa = {xa[6:0], 1'b0} ^ (xa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] inv;
    logic [7:0] pw;

    // Multiplicative inverse as a^254 (maps 0 to 0), then the affine transform.
    always_comb begin
        inv = 8'h01;
        pw  = gf_mul(a, a);
        for (int i = 0; i < 7; i++) begin
            inv = gf_mul(inv, pw);
            pw  = gf_mul(pw, pw);
        end
    end

    assign s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

// state  | meaning
// IDLE   | waiting for key word 0
// LOAD   | collecting key words 1..3
// EXPAND | computing round key rnd (1..10), one per cycle
// DONE   | all round keys valid; a new word restarts loading
// ZERO   | clearing entry rnd (0..10), zeroize builds only
module aes_key_expander #(
    parameter int REG_OUT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_valid,
    input  logic [31:0]  key_data,
`ifdef AES_KEY_ZEROIZE_EN
    input  logic         zeroize,
`endif
    output logic         key_ready,
    input  logic [3:0]   round_key_addr,
    output logic [127:0] round_key,
    output logic         keys_valid,
    output logic         busy
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_EXPAND, S_DONE
`ifdef AES_KEY_ZEROIZE_EN
        , S_ZERO
`endif
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    wcnt, wcnt_nxt;
    logic [3:0]    rnd, rnd_nxt;
    logic [95:0]   key_buf;
    logic [127:0]  prev_key;
    logic [127:0]  rf [0:10];
    logic          rf_we;
    logic [3:0]    rf_waddr;
    logic [127:0]  rf_wdata;
    logic          zero_req;
    logic          xfer;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [31:0]  rot, sub, temp, n0, n1, n2, n3;
    logic [127:0] next_key;

    assign rot = {prev_key[23:0], prev_key[31:24]};
    aes_sbox u_sbox0 (.a(rot[31:24]), .s(sub[31:24]));
    aes_sbox u_sbox1 (.a(rot[23:16]), .s(sub[23:16]));
    aes_sbox u_sbox2 (.a(rot[15:8]),  .s(sub[15:8]));
    aes_sbox u_sbox3 (.a(rot[7:0]),   .s(sub[7:0]));

    assign temp     = sub ^ {rcon(rnd), 24'h0};
    assign n0       = prev_key[127:96] ^ temp;
    assign n1       = prev_key[95:64] ^ n0;
    assign n2       = prev_key[63:32] ^ n1;
    assign n3       = prev_key[31:0] ^ n2;
    assign next_key = {n0, n1, n2, n3};

`ifdef AES_KEY_ZEROIZE_EN
    assign zero_req = zeroize && (state != S_ZERO);
`else
    assign zero_req = 1'b0;
`endif

    // A pending zeroize withdraws ready so no word is half-accepted.
    assign key_ready  = (state == S_IDLE || state == S_LOAD || state == S_DONE) && !zero_req;
    assign busy       = (state != S_IDLE) && (state != S_DONE);
    assign keys_valid = (state == S_DONE);
    assign xfer       = key_valid && key_ready;

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        rnd_nxt   = rnd;
        rf_we     = 1'b0;
        rf_waddr  = rnd;
        rf_wdata  = next_key;
        case (state)
            S_IDLE, S_DONE: begin
                if (xfer) begin
                    state_nxt = S_LOAD;
                    wcnt_nxt  = 2'd1;
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    wcnt_nxt = wcnt + 2'd1;
                    if (wcnt == 2'd3) begin
                        rf_we     = 1'b1;
                        rf_waddr  = 4'd0;
                        rf_wdata  = {key_buf, key_data};
                        state_nxt = S_EXPAND;
                        rnd_nxt   = 4'd1;
                    end
                end
            end
            S_EXPAND: begin
                rf_we = 1'b1;
                if (rnd == 4'd10) state_nxt = S_DONE;
                else              rnd_nxt   = rnd + 4'd1;
            end
`ifdef AES_KEY_ZEROIZE_EN
            S_ZERO: begin
                rf_we    = 1'b1;
                rf_wdata = '0;
                if (rnd == 4'd10) begin
                    state_nxt = S_IDLE;
                    rnd_nxt   = 4'd0;
                end else begin
                    rnd_nxt = rnd + 4'd1;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
        if (zero_req) begin
`ifdef AES_KEY_ZEROIZE_EN
            state_nxt = S_ZERO;
`endif
            rnd_nxt  = 4'd0;
            wcnt_nxt = 2'd0;
            rf_we    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wcnt     <= 2'd0;
            rnd      <= 4'd0;
            key_buf  <= '0;
            prev_key <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            rnd   <= rnd_nxt;
            if (xfer)  key_buf  <= {key_buf[63:0], key_data};
            if (rf_we) prev_key <= rf_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && rf_we) rf[rf_waddr] <= rf_wdata;
    end

    logic [127:0] rd_data;
    assign rd_data = (round_key_addr <= 4'd10) ? rf[round_key_addr] : '0;

    generate
        if (REG_OUT != 0) begin : g_reg_out
            always_ff @(posedge clk) begin
                if (reset) round_key <= '0;
                else       round_key <= rd_data;
            end
        end else begin : g_comb_out
            always_comb round_key = rd_data;
        end
    endgenerate
endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: known-answer table, gapped/reset/overlap sequences,
// random keys against a FIPS-197 word-array model; zeroize checks when AES_KEY_ZEROIZE_EN is set.

module tb_aes_key_expander;
    logic         clk = 1'b0;
    logic         reset;
    logic         key_valid;
    logic [31:0]  key_data;
    logic [3:0]   round_key_addr;
    logic         key_ready, keys_valid, busy;
    logic [127:0] round_key;
    logic         key_ready_c, keys_valid_c, busy_c;
    logic [127:0] round_key_c;
`ifdef AES_KEY_ZEROIZE_EN
    logic         zeroize;
`endif

    always #5 clk = ~clk;

    aes_key_expander #(.REG_OUT(1)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_data(key_data),
`ifdef AES_KEY_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .key_ready(key_ready), .round_key_addr(round_key_addr), .round_key(round_key),
        .keys_valid(keys_valid), .busy(busy)
    );

    aes_key_expander #(.REG_OUT(0)) dut_comb (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_data(key_data),
`ifdef AES_KEY_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .key_ready(key_ready_c), .round_key_addr(round_key_addr), .round_key(round_key_c),
        .keys_valid(keys_valid_c), .busy(busy_c)
    );

    int           n_cmp = 0;
    int           n_err = 0;
    int           busy_drops = 0;
    bit           mon_busy = 1'b0;
    logic [7:0]   sb [0:255];
    logic [127:0] exp_rk [0:10];

    localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    typedef struct {
        logic [127:0] key;
        logic [3:0]   addr;
        logic [127:0] exp;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (mon_busy && !busy && !keys_valid) busy_drops++;
    endtask

    function automatic int gmul(input int a, input int b);
        int r;
        int x;
        r = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (((b >> i) & 1) != 0) r = r ^ x;
            x = x << 1;
            if ((x & 32'h100) != 0) x = x ^ 32'h11b;
        end
        return r;
    endfunction

    task automatic build_sbox();
        int inv;
        int res;
        int bitv;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++) if (gmul(x, y) == 1) inv = y;
            res = 0;
            for (int i = 0; i < 8; i++) begin
                bitv = ((inv >> i) ^ (inv >> ((i + 4) % 8)) ^ (inv >> ((i + 5) % 8))
                      ^ (inv >> ((i + 6) % 8)) ^ (inv >> ((i + 7) % 8)) ^ (32'h63 >> i)) & 1;
                res = res | (bitv << i);
            end
            sb[x] = res[7:0];
        end
    endtask

    task automatic ref_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        int rc;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 1;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ (32'(rc) << 24);
                rc = rc << 1;
                if ((rc & 32'h100) != 0) rc = rc ^ 32'h11b;
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Returns just after the edge that accepts word 3; kv_w0 is keys_valid right after word 0.
    task automatic load_key(input logic [127:0] key, input int gap, input bit mon, output logic kv_w0);
        int g;
        kv_w0 = 1'b0;
        for (int w = 0; w < 4; w++) begin
            key_valid = 1'b1;
            key_data  = key[127-32*w -: 32];
            g = 0;
            while (!key_ready && g < 50) begin
                tick();
                g++;
            end
            check("key_ready_wait", {127'b0, key_ready}, 128'd1);
            tick();
            key_valid = 1'b0;
            if (w == 0) begin
                kv_w0    = keys_valid;
                mon_busy = mon;
            end
            if (w < 3) for (int k = 0; k < gap; k++) tick();
        end
    endtask

    // cyc counts edges from (and including) the word-3 accept edge until keys_valid is seen.
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!keys_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        mon_busy = 1'b0;
    endtask

    task automatic read_rk(input logic [3:0] a, output logic [127:0] r1, output logic [127:0] r0);
        round_key_addr = a;
        #1;
        r0 = round_key_c;
        tick();
        r1 = round_key;
    endtask

    initial begin
        logic [127:0] cur, rk1, rk0, key, old5;
        logic kv;
        int cyc;
        bit have;
        int bad;

        vecs[0] = '{KEY1, 4'd0,  KEY1};
        vecs[1] = '{KEY1, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2] = '{KEY1, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[3] = '{KEY1, 4'd11, 128'h0};
        vecs[4] = '{KEY1, 4'd15, 128'h0};
        vecs[5] = '{128'h0, 4'd1,  128'h62636363626363636263636362636363};
        vecs[6] = '{128'h0, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        vecs[7] = '{128'h0, 4'd0,  128'h0};

        build_sbox();

        reset = 1'b1; key_valid = 1'b0; key_data = '0; round_key_addr = '0;
`ifdef AES_KEY_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        tick();
        tick();
        check("reset_key_ready",  {127'b0, key_ready},  128'd1);
        check("reset_keys_valid", {127'b0, keys_valid}, 128'd0);
        check("reset_busy",       {127'b0, busy},       128'd0);
        check("reset_round_key",  round_key,            128'd0);
        reset = 1'b0;
        tick();

        have = 1'b0;
        cur  = '0;
        for (int i = 0; i < 8; i++) begin
            if (!have || vecs[i].key != cur) begin
                load_key(vecs[i].key, 0, 1'b0, kv);
                if (have) check("valid_drop_after_w0", {127'b0, kv}, 128'd0);
                wait_valid(cyc);
                check("load_latency", 128'(cyc), 128'd11);
                check("keys_valid_comb", {127'b0, keys_valid_c}, 128'd1);
                cur  = vecs[i].key;
                have = 1'b1;
            end
            read_rk(vecs[i].addr, rk1, rk0);
            check($sformatf("vec%0d_reg", i), rk1, vecs[i].exp);
            check($sformatf("vec%0d_comb", i), rk0, vecs[i].exp);
        end

        // Read latency: registered output still holds addr 10 before the edge, zero after.
        read_rk(4'd10, rk1, rk0);
        round_key_addr = 4'd11;
        #1;
        check("lat_before_edge", round_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        check("lat_comb_now",    round_key_c, 128'd0);
        tick();
        check("lat_after_edge",  round_key, 128'd0);

        // Gapped load of KEY1, busy held throughout.
        busy_drops = 0;
        load_key(KEY1, 3, 1'b1, kv);
        wait_valid(cyc);
        check("gap_latency", 128'(cyc), 128'd11);
        check("gap_busy_drops", 128'(busy_drops), 128'd0);
        ref_expand(KEY1);
        for (int a = 0; a < 11; a++) begin
            read_rk(4'(a), rk1, rk0);
            check($sformatf("gap_rk%0d", a), rk1, exp_rk[a]);
        end

        // Reset in the middle of expansion.
        load_key({$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, kv);
        for (int k = 0; k < 5; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_keys_valid", {127'b0, keys_valid}, 128'd0);
        check("midrst_busy",       {127'b0, busy},       128'd0);
        check("midrst_key_ready",  {127'b0, key_ready},  128'd1);
        load_key(KEY1, 0, 1'b0, kv);
        wait_valid(cyc);
        check("midrst_latency", 128'(cyc), 128'd11);
        read_rk(4'd10, rk1, rk0);
        check("midrst_rk10", rk1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_rk(4'd5, rk1, rk0);
        check("midrst_rk5", rk1, exp_rk[5]);

        // Read of entry 5 on the edge that rewrites it returns the old key.
        old5 = exp_rk[5];
        key  = {$urandom, $urandom, $urandom, $urandom};
        load_key(key, 0, 1'b0, kv);
        for (int k = 0; k < 4; k++) tick();
        round_key_addr = 4'd5;
        tick();
        check("overlap_old", round_key, old5);
        ref_expand(key);
        tick();
        check("overlap_new", round_key, exp_rk[5]);
        wait_valid(cyc);
        check("overlap_done", {127'b0, keys_valid}, 128'd1);

        for (int t = 0; t < 6; t++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            load_key(key, int'($urandom_range(0, 2)), 1'b0, kv);
            wait_valid(cyc);
            check("rand_valid", {127'b0, keys_valid}, 128'd1);
            ref_expand(key);
            for (int a = 0; a < 11; a++) begin
                read_rk(4'(a), rk1, rk0);
                check($sformatf("rand%0d_rk%0d_reg", t, a), rk1, exp_rk[a]);
                check($sformatf("rand%0d_rk%0d_comb", t, a), rk0, exp_rk[a]);
            end
        end

`ifdef AES_KEY_ZEROIZE_EN
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        bad = 0;
        for (int k = 0; k < 11; k++) begin
            if (key_ready || keys_valid || !busy) bad++;
            tick();
        end
        check("zero_window", 128'(bad), 128'd0);
        check("zero_exit_ready", {127'b0, key_ready}, 128'd1);
        for (int a = 0; a < 11; a++) begin
            read_rk(4'(a), rk1, rk0);
            check($sformatf("zero_rk%0d", a), rk1, 128'd0);
        end
`else
        bad = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end
endmodule
